cp0_exc_commit: RTL and testbench
=================================

# cp0_exc_commit

Exception-commit end of the CP0 exception path: consumes the prioritised `exception_type` word from the exception encoder and the MTC0/MFC0 datapath, and owns the CP0 state it reads back (Status, Cause, EPC, BadVAddr, Count, Compare). On a committed exception it updates that state at the next clock edge. In the same cycle it raises a pipeline flush with the redirect PC (exception vector or EPC for ERET). It also generates the Count/Compare timer interrupt that feeds back into Cause.IP7.

## Interface
- `VEC_BEV`, 32'hBFC0_0000, vector base when Status.BEV=1
- `VEC_NORM`, 32'h8000_0000, vector base when Status.BEV=0
- `clk`  in  1  single clock, all state on posedge
- `rst`  in  1  asynchronous, active-high reset
- `we_i`  in  1  MTC0 write enable
- `waddr_i`  in  5  MTC0 register number
- `wdata_i`  in  32  MTC0 data
- `raddr_i`  in  5  MFC0 register number
- `rdata_o`  out  32  MFC0 data, combinational from current registers, no write bypass
- `int_i`  in  6  external hardware interrupts, level
- `exception_type_i`  in  32  encoded exception, compared against `cp0_defines.vh` EXC_* macros
- `current_pc_i`  in  32  PC of the excepting instruction
- `is_in_delayslot_i`  in  1  excepting instruction is in a delay slot
- `bad_addr_i`  in  32  faulting data virtual address
- `mem_store_i`  in  1  the data TLB fault was a store
- `status_o`, `cause_o`, `epc_o`, `badvaddr_o`, `count_o`, `compare_o`  out  32 each  register values
- `timer_int_o`  out  1  Cause.TI
- `flush_o`  out  1  exception_type_i ≠ EXC_NONE
- `new_pc_o`  out  32  redirect target, valid when flush_o=1

## Operation
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Reads of other numbers return 0; writes to them are ignored.
- Status writable mask 32'h0040_FF03 (BEV, IM[15:8], EXL, IE). Cause writable bits are IP[9:8] only. EPC, Count and Compare are fully writable. BadVAddr is read-only.
- Cause[15:10] is loaded every cycle with {int_i[5] | TI, int_i[4:0]}. Cause.TI is bit 30, BD bit 31, ExcCode [6:2].
- Count tick: a 1-bit toggle register. Count increments when the toggle is 1, i.e. every second cycle. An MTC0 to Count loads wdata and clears the toggle.
- TI is set when count_o == compare_o, sampled each cycle with Count nonzero or Compare written. An MTC0 to Compare clears TI; the clear wins over a simultaneous set.
- ExcCode mapping:
  - INT → 0x00
  - DATA_MODIFY → 0x01
  - INST_REFILL, INST_INVALID → 0x02
  - DATA_REFILL, DATA_INVALID → 0x03 if mem_store_i, else 0x02
  - INST_ADD_ERR, DATA_ADD_ERR_L → 0x04
  - DATA_ADD_ERR_S → 0x05
  - SYSCALL → 0x08
  - BREAK → 0x09
  - RI → 0x0A
  - OVF → 0x0C
- Non-ERET exception commit:
  - ExcCode is written.
  - If Status.EXL=0: EPC ← current_pc_i − 4 with BD=1 when in a delay slot, else EPC ← current_pc_i with BD=0. If EXL=1, EPC and BD are unchanged.
  - EXL is set to 1.
- BadVAddr ← current_pc_i for INST_ADD_ERR, INST_REFILL and INST_INVALID. BadVAddr ← bad_addr_i for DATA_ADD_ERR_L/S, DATA_REFILL, DATA_INVALID and DATA_MODIFY. Otherwise BadVAddr is unchanged.
- ERET: EXL ← 0; new_pc_o = epc_o. No other field changes.
- Vector:
  - base = BEV ? VEC_BEV : VEC_NORM.
  - INST_REFILL or DATA_REFILL with EXL=0 → base + 0x200 when BEV=1, base + 0x000 when BEV=0.
  - All other exceptions → base + 0x380 when BEV=1, base + 0x180 when BEV=0.
- Same-cycle MTC0 and exception: the exception wins and the MTC0 is dropped entirely. Count and TI still advance.
- An unknown exception_type value ≠ EXC_NONE is treated as RI.

## Timing
- Reset values (asynchronous): status 32'h0040_0000, all other registers 0, tick toggle 0, timer_int_o 0.
- flush_o and new_pc_o are combinational from exception_type_i and the current (pre-edge) register values. There is zero-cycle latency from the encoder.
- Register updates from MTC0 or an exception are visible on outputs one cycle later (the posedge after).
- ERET in the cycle after an MTC0 to EPC uses the new EPC.
- Reset asserted mid-operation clears state immediately; flush_o follows exception_type_i regardless.

## Test plan
- Reset → status_o=0x0040_0000 and all other registers 0. A SYSCALL at pc 0xBFC0_0100 → flush_o=1, new_pc_o=0xBFC0_0380. Next cycle: epc_o=0xBFC0_0100, cause_o[6:2]=0x08, status_o[1]=1.
- Write Status=0 (BEV=0), then OVF at pc 0x8000_1004 in a delay slot → new_pc_o=0x8000_0180. Next cycle: epc_o=0x8000_1000, cause_o[31]=1.
- Second exception (DATA_ADD_ERR_S, bad_addr 0x0000_0003) while EXL=1 → EPC unchanged, ExcCode 0x05, badvaddr_o=0x3. Then ERET → new_pc_o=old EPC and EXL=0 the following cycle.
- INST_REFILL with BEV=0 and EXL=0 → new_pc_o=0x8000_0000. With EXL=1 → 0x8000_0180.
- Compare=4, Count=0 → Count reaches 4 after 8 cycles, then timer_int_o=1 and cause_o[15]=1. MTC0 Compare → timer_int_o=0 next cycle.
- MTC0 Status=0x0000_FF01 in the same cycle as BREAK → Status IM unchanged, EXL=1, ExcCode 0x09.

Source files
------------

// File: rtl/cp0_exc_commit.sv
// ============================================================================
// Module   : cp0_exc_commit
// Brief    : CP0 exception commit: state registers, MTC0/MFC0, redirect PC,
//            Count/Compare timer interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp0_exc_commit #(
    parameter logic [31:0] VEC_BEV  = 32'hBFC0_0000,
    parameter logic [31:0] VEC_NORM = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] exception_type_i,
    input  logic [31:0] current_pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    input  logic        mem_store_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    // Exception encodings shared with the exception encoder
    localparam logic [31:0] c_EXC_NONE       = 32'h0000_0000;
    localparam logic [31:0] c_EXC_INT        = 32'h0000_0001;
    localparam logic [31:0] c_EXC_DATA_MODIFY = 32'h0000_0002;
    localparam logic [31:0] c_EXC_INST_REFILL = 32'h0000_0003;
    localparam logic [31:0] c_EXC_INST_INVALID = 32'h0000_0004;
    localparam logic [31:0] c_EXC_DATA_REFILL = 32'h0000_0005;
    localparam logic [31:0] c_EXC_DATA_INVALID = 32'h0000_0006;
    localparam logic [31:0] c_EXC_INST_ADD_ERR = 32'h0000_0007;
    localparam logic [31:0] c_EXC_DATA_ADD_ERR_L = 32'h0000_0008;
    localparam logic [31:0] c_EXC_DATA_ADD_ERR_S = 32'h0000_0009;
    localparam logic [31:0] c_EXC_SYSCALL    = 32'h0000_000A;
    localparam logic [31:0] c_EXC_BREAK      = 32'h0000_000B;
    localparam logic [31:0] c_EXC_RI         = 32'h0000_000C;
    localparam logic [31:0] c_EXC_OVF        = 32'h0000_000D;
    localparam logic [31:0] c_EXC_ERET       = 32'h0000_000E;

    localparam logic [4:0]  c_REG_BADVADDR = 5'd8;
    localparam logic [4:0]  c_REG_COUNT    = 5'd9;
    localparam logic [4:0]  c_REG_COMPARE  = 5'd11;
    localparam logic [4:0]  c_REG_STATUS   = 5'd12;
    localparam logic [4:0]  c_REG_CAUSE    = 5'd13;
    localparam logic [4:0]  c_REG_EPC      = 5'd14;

    localparam logic [31:0] c_STATUS_MASK  = 32'h0040_FF03;
    localparam logic [31:0] c_STATUS_RST   = 32'h0040_0000;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;
    logic        ti_d;

    logic        w_exc;
    logic        w_eret;
    logic        w_mtc0;
    logic        w_exl;
    logic        w_bev;
    logic [4:0]  w_exccode;
    logic        w_refill;
    logic        w_bad_inst;
    logic        w_bad_data;
    logic [31:0] w_base;
    logic [31:0] w_offset;

    assign w_exc  = (exception_type_i != c_EXC_NONE);
    assign w_eret = (exception_type_i == c_EXC_ERET);
    // A committing exception drops any MTC0 issued in the same cycle
    assign w_mtc0 = we_i && !w_exc;
    assign w_exl  = status_q[1];
    assign w_bev  = status_q[22];

    always_comb begin
        w_exccode  = 5'h0A;
        w_refill   = 1'b0;
        w_bad_inst = 1'b0;
        w_bad_data = 1'b0;
        case (exception_type_i)
            c_EXC_INT:            w_exccode = 5'h00;
            c_EXC_DATA_MODIFY: begin
                w_exccode  = 5'h01;
                w_bad_data = 1'b1;
            end
            c_EXC_INST_REFILL: begin
                w_exccode  = 5'h02;
                w_refill   = 1'b1;
                w_bad_inst = 1'b1;
            end
            c_EXC_INST_INVALID: begin
                w_exccode  = 5'h02;
                w_bad_inst = 1'b1;
            end
            c_EXC_DATA_REFILL: begin
                w_exccode  = mem_store_i ? 5'h03 : 5'h02;
                w_refill   = 1'b1;
                w_bad_data = 1'b1;
            end
            c_EXC_DATA_INVALID: begin
                w_exccode  = mem_store_i ? 5'h03 : 5'h02;
                w_bad_data = 1'b1;
            end
            c_EXC_INST_ADD_ERR: begin
                w_exccode  = 5'h04;
                w_bad_inst = 1'b1;
            end
            c_EXC_DATA_ADD_ERR_L: begin
                w_exccode  = 5'h04;
                w_bad_data = 1'b1;
            end
            c_EXC_DATA_ADD_ERR_S: begin
                w_exccode  = 5'h05;
                w_bad_data = 1'b1;
            end
            c_EXC_SYSCALL:        w_exccode = 5'h08;
            c_EXC_BREAK:          w_exccode = 5'h09;
            c_EXC_RI:             w_exccode = 5'h0A;
            c_EXC_OVF:            w_exccode = 5'h0C;
            default:              w_exccode = 5'h0A;
        endcase
    end

    // Redirect target
    always_comb begin
        w_base = w_bev ? VEC_BEV : VEC_NORM;
        if (w_refill && !w_exl) begin
            w_offset = w_bev ? 32'h0000_0200 : 32'h0000_0000;
        end else begin
            w_offset = w_bev ? 32'h0000_0380 : 32'h0000_0180;
        end
        flush_o  = w_exc;
        new_pc_o = w_eret ? epc_q : (w_base + w_offset);
    end

    // Timer: count advances every second cycle; TI is sticky until Compare is written
    always_comb begin
        tick_d  = ~tick_q;
        count_d = tick_q ? (count_q + 32'd1) : count_q;
        if (w_mtc0 && (waddr_i == c_REG_COUNT)) begin
            tick_d  = 1'b0;
            count_d = wdata_i;
        end
        ti_d = cause_q[30];
        if ((count_q == compare_q) && (count_q != 32'd0)) begin
            ti_d = 1'b1;
        end
        if (w_mtc0 && (waddr_i == c_REG_COMPARE)) begin
            ti_d = 1'b0;
        end
    end

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;

        cause_d[30]    = ti_d;
        cause_d[15:10] = {int_i[5] | ti_d, int_i[4:0]};

        if (w_mtc0) begin
            case (waddr_i)
                c_REG_COMPARE: compare_d = wdata_i;
                c_REG_STATUS:  status_d  = (status_q & ~c_STATUS_MASK) | (wdata_i & c_STATUS_MASK);
                c_REG_CAUSE:   cause_d[9:8] = wdata_i[9:8];
                c_REG_EPC:     epc_d     = wdata_i;
                default:       ;
            endcase
        end

        if (w_eret) begin
            status_d[1] = 1'b0;
        end else if (w_exc) begin
            cause_d[6:2] = w_exccode;
            if (!w_exl) begin
                if (is_in_delayslot_i) begin
                    epc_d       = current_pc_i - 32'd4;
                    cause_d[31] = 1'b1;
                end else begin
                    epc_d       = current_pc_i;
                    cause_d[31] = 1'b0;
                end
            end
            status_d[1] = 1'b1;
            if (w_bad_inst) begin
                badvaddr_d = current_pc_i;
            end else if (w_bad_data) begin
                badvaddr_d = bad_addr_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= c_STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            tick_q     <= 1'b0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        case (raddr_i)
            c_REG_BADVADDR: rdata_o = badvaddr_q;
            c_REG_COUNT:    rdata_o = count_q;
            c_REG_COMPARE:  rdata_o = compare_q;
            c_REG_STATUS:   rdata_o = status_q;
            c_REG_CAUSE:    rdata_o = cause_q;
            c_REG_EPC:      rdata_o = epc_q;
            default:        rdata_o = 32'd0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = cause_q[30];

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_commit.sv
// ============================================================================
// Module   : tb_cp0_exc_commit
// Brief    : Self-checking bench for cp0_exc_commit (vector table, directed
//            sequences, randomized run against a behavioural model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cp0_exc_commit;

    localparam logic [31:0] c_EXC_NONE   = 32'h00, c_EXC_INT = 32'h01, c_EXC_DMOD = 32'h02;
    localparam logic [31:0] c_EXC_IREF   = 32'h03, c_EXC_IINV = 32'h04, c_EXC_DREF = 32'h05;
    localparam logic [31:0] c_EXC_DINV   = 32'h06, c_EXC_IADE = 32'h07, c_EXC_DADEL = 32'h08;
    localparam logic [31:0] c_EXC_DADES  = 32'h09, c_EXC_SYS = 32'h0A, c_EXC_BRK = 32'h0B;
    localparam logic [31:0] c_EXC_RI     = 32'h0C, c_EXC_OVF = 32'h0D, c_EXC_ERET = 32'h0E;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0, raddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic [5:0]  int_i = '0;
    logic [31:0] exception_type_i = '0, current_pc_i = '0, bad_addr_i = '0;
    logic        is_in_delayslot_i = 1'b0, mem_store_i = 1'b0;
    logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, new_pc_o;
    logic        timer_int_o, flush_o;

    cp0_exc_commit dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i),
        .exception_type_i(exception_type_i), .current_pc_i(current_pc_i),
        .is_in_delayslot_i(is_in_delayslot_i), .bad_addr_i(bad_addr_i),
        .mem_store_i(mem_store_i), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .badvaddr_o(badvaddr_o), .count_o(count_o),
        .compare_o(compare_o), .timer_int_o(timer_int_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0; int_i = '0;
        exception_type_i = c_EXC_NONE; current_pc_i = '0; bad_addr_i = '0;
        is_in_delayslot_i = 1'b0; mem_store_i = 1'b0;
    endtask

    // Called just after a posedge; returns still well before the next edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_status, m_epc, m_bad, m_compare, m_cnt_base;
    int unsigned m_cycles;
    logic        m_bd, m_ti;
    logic [4:0]  m_code;
    logic [1:0]  m_ip98;
    logic [5:0]  m_iphi;

    function automatic logic [31:0] m_count();
        return m_cnt_base + 32'(m_cycles / 2);
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'd0, m_iphi, m_ip98, 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic [4:0] code_of(input logic [31:0] t, input logic st);
        case (t)
            c_EXC_INT:                return 5'h00;
            c_EXC_DMOD:               return 5'h01;
            c_EXC_IREF, c_EXC_IINV:   return 5'h02;
            c_EXC_DREF, c_EXC_DINV:   return st ? 5'h03 : 5'h02;
            c_EXC_IADE, c_EXC_DADEL:  return 5'h04;
            c_EXC_DADES:              return 5'h05;
            c_EXC_SYS:                return 5'h08;
            c_EXC_BRK:                return 5'h09;
            c_EXC_OVF:                return 5'h0C;
            default:                  return 5'h0A;
        endcase
    endfunction

    function automatic logic [31:0] m_new_pc(input logic [31:0] t);
        logic bev;
        logic [31:0] base;
        bev  = m_status[22];
        base = bev ? 32'hBFC0_0000 : 32'h8000_0000;
        if (t == c_EXC_ERET) return m_epc;
        if ((t == c_EXC_IREF || t == c_EXC_DREF) && !m_status[1])
            return base + (bev ? 32'h200 : 32'h0);
        return base + (bev ? 32'h380 : 32'h180);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bad;
            5'd9:  return m_count();
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause();
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_status = 32'h0040_0000; m_epc = 0; m_bad = 0; m_compare = 0; m_cnt_base = 0;
        m_cycles = 0; m_bd = 0; m_ti = 0; m_code = 0; m_ip98 = 0; m_iphi = 0;
    endtask

    task automatic m_step();
        logic exc, wr, ti_n;
        logic [31:0] t;
        t    = exception_type_i;
        exc  = (t != c_EXC_NONE);
        wr   = we_i && !exc;
        ti_n = m_ti;
        if (m_count() == m_compare && m_count() != 0) ti_n = 1'b1;
        if (wr && waddr_i == 5'd11) ti_n = 1'b0;
        if (wr && waddr_i == 5'd9) begin
            m_cnt_base = wdata_i;
            m_cycles   = 0;
        end else begin
            m_cycles++;
        end
        m_ti   = ti_n;
        m_iphi = {int_i[5] | ti_n, int_i[4:0]};
        if (wr) begin
            case (waddr_i)
                5'd11: m_compare = wdata_i;
                5'd12: m_status  = (m_status & ~32'h0040_FF03) | (wdata_i & 32'h0040_FF03);
                5'd13: m_ip98    = wdata_i[9:8];
                5'd14: m_epc     = wdata_i;
                default: ;
            endcase
        end
        if (t == c_EXC_ERET) begin
            m_status[1] = 1'b0;
        end else if (exc) begin
            m_code = code_of(t, mem_store_i);
            if (!m_status[1]) begin
                m_epc = is_in_delayslot_i ? current_pc_i - 4 : current_pc_i;
                m_bd  = is_in_delayslot_i;
            end
            m_status[1] = 1'b1;
            if (t == c_EXC_IADE || t == c_EXC_IREF || t == c_EXC_IINV)
                m_bad = current_pc_i;
            else if (t == c_EXC_DADEL || t == c_EXC_DADES || t == c_EXC_DREF ||
                     t == c_EXC_DINV || t == c_EXC_DMOD)
                m_bad = bad_addr_i;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] etype;
        logic        store;
        logic        exp_flush;
        logic [31:0] exp_pc;
        logic [4:0]  exp_code;
        logic [31:0] exp_bad;
    } vec_t;

    localparam logic [31:0] c_TPC  = 32'hBFC0_0040;
    localparam logic [31:0] c_TBAD = 32'h1234_0000;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{c_EXC_NONE,  1'b0, 1'b0, 32'h0,         5'h00, 32'h0};
        vecs[1]  = '{c_EXC_INT,   1'b0, 1'b1, 32'hBFC0_0380, 5'h00, 32'h0};
        vecs[2]  = '{c_EXC_SYS,   1'b0, 1'b1, 32'hBFC0_0380, 5'h08, 32'h0};
        vecs[3]  = '{c_EXC_IREF,  1'b0, 1'b1, 32'hBFC0_0200, 5'h02, c_TPC};
        vecs[4]  = '{c_EXC_IINV,  1'b0, 1'b1, 32'hBFC0_0380, 5'h02, c_TPC};
        vecs[5]  = '{c_EXC_DREF,  1'b1, 1'b1, 32'hBFC0_0200, 5'h03, c_TBAD};
        vecs[6]  = '{c_EXC_DINV,  1'b0, 1'b1, 32'hBFC0_0380, 5'h02, c_TBAD};
        vecs[7]  = '{c_EXC_DMOD,  1'b0, 1'b1, 32'hBFC0_0380, 5'h01, c_TBAD};
        vecs[8]  = '{c_EXC_IADE,  1'b0, 1'b1, 32'hBFC0_0380, 5'h04, c_TPC};
        vecs[9]  = '{c_EXC_DADEL, 1'b0, 1'b1, 32'hBFC0_0380, 5'h04, c_TBAD};
        vecs[10] = '{c_EXC_DADES, 1'b0, 1'b1, 32'hBFC0_0380, 5'h05, c_TBAD};
        vecs[11] = '{c_EXC_BRK,   1'b0, 1'b1, 32'hBFC0_0380, 5'h09, 32'h0};
        vecs[12] = '{c_EXC_RI,    1'b0, 1'b1, 32'hBFC0_0380, 5'h0A, 32'h0};
        vecs[13] = '{c_EXC_OVF,   1'b0, 1'b1, 32'hBFC0_0380, 5'h0C, 32'h0};
        vecs[14] = '{32'h77,      1'b0, 1'b1, 32'hBFC0_0380, 5'h0A, 32'h0};
        vecs[15] = '{c_EXC_ERET,  1'b0, 1'b1, 32'h0,         5'h00, 32'h0};

        idle_inputs();
        tick();

        for (int i = 0; i < 16; i++) begin
            do_reset();
            exception_type_i = vecs[i].etype;
            current_pc_i     = c_TPC;
            bad_addr_i       = c_TBAD;
            mem_store_i      = vecs[i].store;
            #2;
            check($sformatf("vec%0d flush", i), 32'(flush_o), 32'(vecs[i].exp_flush));
            if (vecs[i].exp_flush) check($sformatf("vec%0d new_pc", i), new_pc_o, vecs[i].exp_pc);
            tick();
            idle_inputs();
            check($sformatf("vec%0d exccode", i), 32'(cause_o[6:2]), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d badvaddr", i), badvaddr_o, vecs[i].exp_bad);
        end

        // Reset values, then SYSCALL from the boot vector region
        tick();
        do_reset();
        check("rst status", status_o, 32'h0040_0000);
        check("rst cause", cause_o, 32'h0);
        check("rst epc", epc_o, 32'h0);
        check("rst count", count_o, 32'h0);
        check("rst compare", compare_o, 32'h0);
        check("rst timer", 32'(timer_int_o), 32'h0);
        exception_type_i = c_EXC_SYS; current_pc_i = 32'hBFC0_0100;
        #2;
        check("sys flush", 32'(flush_o), 32'h1);
        check("sys new_pc", new_pc_o, 32'hBFC0_0380);
        tick();
        idle_inputs();
        check("sys epc", epc_o, 32'hBFC0_0100);
        check("sys code", 32'(cause_o[6:2]), 32'h08);
        check("sys exl", 32'(status_o[1]), 32'h1);

        // BEV=0, OVF in a delay slot
        mtc0(5'd12, 32'h0);
        exception_type_i = c_EXC_OVF; current_pc_i = 32'h8000_1004; is_in_delayslot_i = 1'b1;
        #2;
        check("ovf new_pc", new_pc_o, 32'h8000_0180);
        tick();
        idle_inputs();
        check("ovf epc", epc_o, 32'h8000_1000);
        check("ovf bd", 32'(cause_o[31]), 32'h1);

        // Nested exception with EXL=1, then ERET
        exception_type_i = c_EXC_DADES; current_pc_i = 32'h8000_2000; bad_addr_i = 32'h3;
        tick();
        idle_inputs();
        check("nest epc", epc_o, 32'h8000_1000);
        check("nest code", 32'(cause_o[6:2]), 32'h05);
        check("nest bad", badvaddr_o, 32'h3);
        exception_type_i = c_EXC_ERET;
        #2;
        check("eret new_pc", new_pc_o, 32'h8000_1000);
        tick();
        idle_inputs();
        check("eret exl", 32'(status_o[1]), 32'h0);

        // Refill vectors with EXL=0 and EXL=1
        exception_type_i = c_EXC_IREF; current_pc_i = 32'h0040_0000;
        #2;
        check("iref exl0", new_pc_o, 32'h8000_0000);
        tick();
        #2;
        check("iref exl1", new_pc_o, 32'h8000_0180);
        tick();
        idle_inputs();

        // Timer interrupt
        do_reset();
        mtc0(5'd11, 32'd4);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("tmr count", count_o, 32'd4);
        check("tmr ti pre", 32'(timer_int_o), 32'h0);
        tick();
        check("tmr ti", 32'(timer_int_o), 32'h1);
        check("tmr ip7", 32'(cause_o[15]), 32'h1);
        mtc0(5'd11, 32'd100);
        check("tmr clr", 32'(timer_int_o), 32'h0);

        // MTC0 dropped by a simultaneous BREAK; ERET right after MTC0 EPC
        do_reset();
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000_FF01;
        exception_type_i = c_EXC_BRK; current_pc_i = 32'hBFC0_0010;
        tick();
        idle_inputs();
        check("brk status", status_o, 32'h0040_0002);
        check("brk code", 32'(cause_o[6:2]), 32'h09);
        mtc0(5'd14, 32'h1234_5678);
        exception_type_i = c_EXC_ERET;
        #2;
        check("eret fresh epc", new_pc_o, 32'h1234_5678);
        tick();
        idle_inputs();

        // Randomized run against the model
        do_reset();
        m_reset();
        for (int n = 0; n < 400; n++) begin
            logic [4:0] regs[8];
            logic [31:0] etypes[16];
            regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
            for (int k = 0; k < 15; k++) etypes[k] = 32'(k);
            etypes[15] = 32'h55;
            we_i    = ($urandom_range(0, 2) == 0);
            waddr_i = regs[$urandom_range(0, 7)];
            wdata_i = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 12)) : $urandom;
            raddr_i = regs[$urandom_range(0, 7)];
            int_i   = 6'($urandom);
            exception_type_i  = ($urandom_range(0, 9) < 7) ? c_EXC_NONE : etypes[$urandom_range(1, 15)];
            current_pc_i      = $urandom & 32'hFFFF_FFFC;
            bad_addr_i        = $urandom;
            is_in_delayslot_i = 1'($urandom);
            mem_store_i       = 1'($urandom);
            #2;
            check("rnd flush", 32'(flush_o), 32'(exception_type_i != c_EXC_NONE));
            if (exception_type_i != c_EXC_NONE) check("rnd new_pc", new_pc_o, m_new_pc(exception_type_i));
            check("rnd rdata", rdata_o, m_read(raddr_i));
            check("rnd status", status_o, m_status);
            check("rnd cause", cause_o, m_cause());
            check("rnd epc", epc_o, m_epc);
            check("rnd bad", badvaddr_o, m_bad);
            check("rnd count", count_o, m_count());
            check("rnd compare", compare_o, m_compare);
            check("rnd timer", 32'(timer_int_o), 32'(m_ti));
            m_step();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
